// File: rtl/key_debounce.sv
// Key pad conditioner: 2-flop sync + stability-window FSM; long-press pulse built only with KEY_LONG_PRESS_EN.
// Press/release accepted DEBOUNCE_CYCLES+3 edges after the pad settles; no backpressure, outputs registered.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_in,
    output logic             key_level,
    output logic             key_press,
    output logic             key_release,
    output logic             key_long,
    output logic [CNT_W-1:0] press_count
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
            $error("key_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [DW-1:0]    r_dcnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_count;
    logic             w_act;

    // Normalise the synchronised pad so that 1 always means pressed.
    assign w_act = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= (KEY_ACTIVE_LOW != 0);
            r_sync2 <= (KEY_ACTIVE_LOW != 0);
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int HW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] r_hcnt;
    logic          r_long_done;
    logic          r_long;

    assign key_long = r_long;
`else
    assign key_long = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dcnt      <= '0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_count     <= '0;
`ifdef KEY_LONG_PRESS_EN
            r_hcnt      <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_long    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_act) begin
                        r_state <= PRESS_WAIT;
                        r_dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_act) begin
                        r_state <= IDLE;
                    end else if (r_dcnt == D_MAX) begin
                        r_state     <= HELD;
                        r_level     <= 1'b1;
                        r_press     <= 1'b1;
                        r_count     <= r_count + 1'b1;
`ifdef KEY_LONG_PRESS_EN
                        r_hcnt      <= '0;
                        r_long_done <= 1'b0;
`endif
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_act) begin
                        r_state <= RELEASE_WAIT;
                        r_dcnt  <= '0;
                    end
`ifdef KEY_LONG_PRESS_EN
                    // hcnt saturates at H_MAX so the long pulse fires once per press.
                    else if (r_hcnt == H_MAX) begin
                        if (!r_long_done) begin
                            r_long      <= 1'b1;
                            r_long_done <= 1'b1;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (w_act) begin
                        r_state <= HELD;
                    end else if (r_dcnt == D_MAX) begin
                        r_state   <= IDLE;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign press_count = r_count;

endmodule
